// File: rtl/kronos_fetch.sv
// Instruction fetch stage: a single-outstanding-request bus master feeding decode
// through an output register plus a one-entry skid buffer, with branch redirect/flush.
module kronos_fetch #(
  parameter logic [31:0] BOOT_ADDR = 32'h0
) (
  input  logic        clk,
  input  logic        rstz,
  output logic [31:0] instr_addr,
  output logic        instr_req,
  input  logic [31:0] instr_data,
  input  logic        instr_ack,
  output logic [63:0] fetch,          // {pc, ir}
  output logic        fetch_vld,
  input  logic        fetch_rdy,
  input  logic        branch,
  input  logic [31:0] branch_target
);

  typedef enum logic [1:0] {INIT, FETCH, DRAIN} state_t;

  localparam logic [31:0] NOP = 32'h0000_0013;

  state_t      state, state_next;
  logic        skid_vld;
  logic [63:0] skid;
  logic [31:0] pending_pc;
  logic [31:0] target_pc;
  logic        ack_fetch;
  logic        req_open;
  logic        unused_tgt_lsb;

  assign target_pc      = {branch_target[31:2], 2'b00};
  assign unused_tgt_lsb = ^branch_target[1:0];

  assign instr_req = (state == FETCH && !skid_vld) || state == DRAIN;
  assign ack_fetch = (state == FETCH) && instr_req && instr_ack;
  // A request still open after this edge must be drained before redirecting.
  assign req_open  = instr_req && !instr_ack;

  always_ff @(posedge clk or negedge rstz) begin
    if (!rstz) state <= INIT;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    if (branch) begin
      state_next = req_open ? DRAIN : FETCH;
    end else begin
      case (state)
        INIT:    state_next = FETCH;
        FETCH:   state_next = FETCH;
        DRAIN:   if (instr_ack) state_next = FETCH;
        default: state_next = INIT;
      endcase
    end
  end

  // Bus address and decode-facing output slot
  always_ff @(posedge clk or negedge rstz) begin
    if (!rstz) begin
      instr_addr <= BOOT_ADDR;
      fetch      <= {32'h0, NOP};
      fetch_vld  <= 1'b0;
      skid_vld   <= 1'b0;
    end else if (branch) begin
      fetch_vld <= 1'b0;
      skid_vld  <= 1'b0;
      if (!req_open) instr_addr <= target_pc;
    end else begin
      if (ack_fetch)
        instr_addr <= instr_addr + 32'd4;
      else if (state == DRAIN && instr_ack)
        instr_addr <= pending_pc;

      // An ack is only possible with the skid empty, so skid never overflows.
      if (ack_fetch && (!fetch_vld || fetch_rdy)) begin
        fetch     <= {instr_addr, instr_data};
        fetch_vld <= 1'b1;
      end else if (ack_fetch) begin
        skid_vld <= 1'b1;
      end else if (skid_vld && fetch_rdy) begin
        fetch    <= skid;
        skid_vld <= 1'b0;
      end else if (fetch_rdy) begin
        fetch_vld <= 1'b0;
      end
    end
  end

  // Skid payload and redirect PC carry no reset; their valid/state qualifiers do.
  always_ff @(posedge clk) begin
    if (!branch && ack_fetch && fetch_vld && !fetch_rdy)
      skid <= {instr_addr, instr_data};
    if (branch && req_open)
      pending_pc <= target_pc;
  end

endmodule

// File: doc/kronos_fetch.md
KRONOS_FETCH -- requirements
Module: kronos_fetch

Interface
REQ-001 SHALL have parameter: BOOT_ADDR, 32'h0, PC of first fetch after reset.
REQ-002 SHALL have port: clk  input  1  single clock; all state on rising edge.
REQ-003 SHALL have port: rstz  input  1  asynchronous active-low reset.
REQ-004 SHALL have port: instr_addr  output  32  instruction bus address; bits [1:0] always 0.
REQ-005 SHALL have port: instr_req  output  1  instruction bus request.
REQ-006 SHALL have port: instr_data  input  32  instruction bus read data.
REQ-007 SHALL have port: instr_ack  input  1  instr_data valid; completes the current request.
REQ-008 SHALL have port: fetch  output  pipeIFID_t  fetched {pc, ir} to decode.
REQ-009 SHALL have port: fetch_vld  output  1  fetch holds a valid instruction.
REQ-010 SHALL have port: fetch_rdy  input  1  decode accepts fetch this cycle.
REQ-011 SHALL have port: branch  input  1  redirect/flush pulse.
REQ-012 SHALL have port: branch_target  input  32  redirect PC; bits [1:0] ignored.

Function
REQ-013 SHALL use one-outstanding-request bus semantics: once asserted, instr_req and instr_addr stay stable until the cycle instr_ack=1.
REQ-014 SHALL implement states INIT, FETCH and DRAIN; INIT SHALL go to FETCH unconditionally on the first edge after reset release.
REQ-015 SHALL assert instr_req = (state==FETCH && !skid_vld) || state==DRAIN.
REQ-016 SHALL, on an ack in FETCH without branch, advance instr_addr by 4 modulo 2^32 (32'hFFFFFFFC wraps to 0), so that back-to-back combinational acks give one instruction per cycle.
REQ-017 SHALL route ack data in FETCH as follows: if !fetch_vld || fetch_rdy, load fetch <= {instr_addr, instr_data} with fetch_vld=1; otherwise load the single-entry skid buffer (skid_vld=1).
REQ-018 SHALL, while skid_vld=1 and fetch_rdy=1, move skid into fetch (fetch_vld stays 1) and clear skid_vld.
REQ-019 SHALL clear fetch_vld when fetch_rdy=1, skid is empty and no ack is accepted.
REQ-020 SHALL hold fetch contents when fetch_vld=1 and fetch_rdy=0, and never drop or reorder instructions.
REQ-021 SHALL, when branch=1, take priority over all other events at that edge: fetch_vld<=0, skid_vld<=0, and any ack data that cycle discarded.
REQ-022 SHALL, on branch with instr_req=1 and instr_ack=0, enter DRAIN, keep the old instr_addr, and latch branch_target with [1:0]=0 as the pending PC.
REQ-023 SHALL, on branch with no unacked request (instr_req=0, or instr_ack=1), load instr_addr <= {branch_target[31:2],2'b00} and go to FETCH.
REQ-024 SHALL, in DRAIN, discard the ack data, then load instr_addr with the pending PC and go to FETCH.
REQ-025 SHALL, on a branch during DRAIN, overwrite the pending PC; the latest branch wins.
REQ-026 SHALL never assert fetch_vld from DRAIN or INIT.
REQ-027 SHALL have fetch-visible latency from ack to fetch_vld of exactly 1 cycle when the output slot is free.

Reset
REQ-028 SHALL, while rstz=0, asynchronously set: state=INIT, instr_addr=BOOT_ADDR, instr_req=0, fetch_vld=0, skid_vld=0, fetch.pc=0, fetch.ir=32'h00000013 (NOP).
REQ-029 SHALL, on reset asserted mid-request, abandon the request; the first request after release SHALL be to BOOT_ADDR.

Verification
REQ-030 SHALL verify streaming: BOOT_ADDR=0, ack every cycle, fetch_rdy=1 -> fetch.pc 0,4,8,... on consecutive cycles, fetch_vld continuous.
REQ-031 SHALL verify backpressure: fetch_rdy=0 for 5 cycles with ack always 1 -> at most 2 instructions buffered, instr_req=0 while skid full; on release, pcs delivered in order with no gap or duplicate.
REQ-032 SHALL verify branch during a pending request: req at 0x10 unacked, branch to 0x200 -> instr_req held at 0x10 until ack, data dropped, next request 0x200, first fetch.pc=0x200.
REQ-033 SHALL verify branch coinciding with ack and a full skid: fetch_vld=0 next cycle, data dropped, next request = target.
REQ-034 SHALL verify wrap and alignment: branch_target=32'hFFFFFFFE -> request 32'hFFFFFFFC, then 32'h0.
REQ-035 SHALL verify async reset mid-stream: rstz low for 1 cycle between clock edges -> outputs take REQ-028 values immediately, and the first post-reset request is to BOOT_ADDR.
